// File: rtl/mac_accumulator.sv
// Aligns sign/exponent/mantissa products to signed fixed point and accumulates
// i_last-delimited vectors, presenting each saturating sum on a valid/ready port.
module mac_accumulator #(
  parameter int ACC_W = 56,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_sign,
  input  logic [4:0]              i_exp,
  input  logic [17:0]             i_mant,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [ACC_W-1:0] o_acc,
  output logic                    o_sat,
  output logic [CNT_W-1:0]        o_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t               state, state_nx;
  logic                 s1_val, s1_last;
  logic [ACC_W-1:0]     s1_prod;
  logic [ACC_W-1:0]     mag, aligned;
  logic [ACC_W-1:0]     acc, base, acc_nx;
  logic [ACC_W:0]       sum_ext;
  logic                 ovf, take, sat;
  logic [CNT_W-1:0]     cnt, cnt_nx;

  // Ready depends on registers only, so there is no combinational path from o_ready.
  assign i_ready = !s1_val || (state != DONE);
  assign take    = s1_val && (state != DONE);

  always_comb begin
    mag     = ACC_W'(i_mant) << i_exp;
    aligned = i_sign ? (~mag + 1'b1) : mag;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_val  <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
    end else if (i_ready) begin
      s1_val <= i_valid;
      if (i_valid) begin
        s1_last <= i_last;
        s1_prod <= aligned;
      end
    end
  end

  // A fresh vector adds onto zero, which keeps one adder for both IDLE and ACC.
  always_comb begin
    base    = (state == IDLE) ? '0 : acc;
    sum_ext = {base[ACC_W-1], base} + {s1_prod[ACC_W-1], s1_prod};
    ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (!ovf)
      acc_nx = sum_ext[ACC_W-1:0];
    else
      acc_nx = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    if (state == IDLE)
      cnt_nx = CNT_W'(1);
    else
      cnt_nx = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACC: if (s1_val) state_nx = s1_last ? DONE : ACC;
      DONE:      if (o_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        sat <= ((state == IDLE) ? 1'b0 : sat) | ovf;
      end
    end
  end

  assign o_valid = (state == DONE);
  assign o_acc   = acc;
  assign o_sat   = sat;
  assign o_cnt   = cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a reference model predicts each vector
// result at input-transfer time; results are checked as the DUT hands them off.
module tb_mac_accumulator;

  localparam int ACC_W = 56;
  localparam int CNT_W = 8;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    i_valid, i_ready, i_sign, i_last;
  logic [4:0]              i_exp;
  logic [17:0]             i_mant;
  logic                    o_valid, o_ready, o_sat;
  logic signed [ACC_W-1:0] o_acc;
  logic [CNT_W-1:0]        o_cnt;

  mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .i_ready(i_ready), .i_sign(i_sign), .i_exp(i_exp),
    .i_mant(i_mant), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_acc(o_acc), .o_sat(o_sat), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {longint acc; bit sat; int cnt;} exp_t;
  exp_t   sbq[$];
  int     n_tests = 0, n_fail = 0;
  int     rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random
  bit     gap_en = 1'b0;
  bit     in_vec = 1'b0;
  longint m_acc;
  bit     m_sat;
  int     m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(want));
    end
  endtask

  function automatic void model(input bit s, input logic [4:0] e, input logic [17:0] m, input bit l);
    longint p, sum;
    p = longint'(m) << e;
    if (s) p = -p;
    if (!in_vec) begin
      m_acc = p; m_cnt = 1; m_sat = 1'b0; in_vec = 1'b1;
    end else begin
      sum = m_acc + p;
      if (sum > MAXV) begin m_acc = MAXV; m_sat = 1'b1; end
      else if (sum < MINV) begin m_acc = MINV; m_sat = 1'b1; end
      else m_acc = sum;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end
    if (l) begin
      sbq.push_back('{acc: m_acc, sat: m_sat, cnt: m_cnt});
      in_vec = 1'b0;
    end
  endfunction

  // One cycle: drive at the negedge, then log whatever transfers the next posedge will make.
  task automatic step(input bit v, input bit s, input logic [4:0] e, input logic [17:0] m,
                      input bit l, output bit taken);
    exp_t x;
    @(negedge clk);
    i_valid = v;
    i_sign  = v ? s : 1'($urandom_range(0, 1));
    i_exp   = v ? e : 5'($urandom_range(0, 31));
    i_mant  = v ? m : 18'($urandom_range(0, 262143));
    i_last  = v ? l : 1'($urandom_range(0, 1));
    o_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    taken = v && i_ready;
    if (taken) model(s, e, m, l);
    if (o_valid && o_ready) begin
      if (sbq.size() == 0) check("spurious_result", 1, 0);
      else begin
        x = sbq.pop_front();
        check("acc", o_acc, x.acc);
        check("sat", o_sat, x.sat);
        check("cnt", o_cnt, x.cnt);
      end
    end
  endtask

  task automatic idle();
    bit t;
    step(1'b0, 1'b0, 5'd0, 18'd0, 1'b0, t);
  endtask

  task automatic send(input bit s, input logic [4:0] e, input logic [17:0] m, input bit l);
    bit t;
    int tries = 0;
    if (gap_en) while ($urandom_range(0, 3) == 0) idle();
    do begin
      step(1'b1, s, e, m, l, t);
      tries++;
    end while (!t && tries < 500);
    if (!t) check("send_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin idle(); n++; end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
    idle();
  endtask

  initial begin
    bit   t;
    int   got, idx, len;
    longint hold_acc;
    logic [17:0] bm [4];

    rstn = 1'b0; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_mant = '0;
    i_last = 1'b0; o_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_i_ready", i_ready, 1);
    check("rst_o_acc", o_acc, 0);
    check("rst_o_cnt", o_cnt, 0);
    check("rst_o_sat", o_sat, 0);
    rstn = 1'b1;

    // Basic vector and latency
    rdy_mode = 1;
    send(1'b0, 5'd2, 18'd3, 1'b0);
    send(1'b1, 5'd0, 18'd5, 1'b0);
    send(1'b0, 5'd4, 18'd1, 1'b1);
    check("basic_expect", sbq.size() == 1 ? sbq[0].acc : 0, 23);
    idle();
    check("lat_not_yet", o_valid, 0);
    idle();
    check("lat_valid", o_valid, 1);
    drain();

    // Positive and negative saturation
    for (int k = 0; k < 65; k++) send(1'b0, 5'd31, 18'd262143, k == 64);
    drain();
    for (int k = 0; k < 65; k++) send(1'b1, 5'd31, 18'd262143, k == 64);
    drain();

    // Backpressure: one product parks in stage 1, then the input stalls
    send(1'b0, 5'd3, 18'd9, 1'b0);
    send(1'b1, 5'd1, 18'd4, 1'b1);
    rdy_mode = 0;
    got = 0;
    while (!o_valid && got < 20) begin idle(); got++; end
    check("bp_valid", o_valid, 1);
    hold_acc = (sbq.size() != 0) ? sbq[0].acc : 0;
    bm = '{18'd11, 18'd22, 18'd33, 18'd44};
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, 5'd1, bm[idx], idx == 3, t);
      if (t) idx++;
      check("bp_acc_stable", o_acc, hold_acc);
    end
    check("bp_accepted", idx, 1);
    check("bp_stalled", i_ready, 0);
    rdy_mode = 1;
    for (int k = idx; k < 4; k++) send(1'b0, 5'd1, bm[k], k == 3);
    drain();

    // Single-product and zero-mantissa vectors
    send(1'b1, 5'd7, 18'd100, 1'b1);
    check("single_expect", sbq.size() == 1 ? sbq[0].acc : 0, -12800);
    drain();
    send(1'b1, 5'd31, 18'd0, 1'b0);
    send(1'b0, 5'd5, 18'd0, 1'b0);
    send(1'b1, 5'd0, 18'd0, 1'b1);
    drain();

    // Asynchronous reset in the middle of a vector
    send(1'b0, 5'd10, 18'd77, 1'b0);
    send(1'b1, 5'd2, 18'd5, 1'b0);
    send(1'b0, 5'd4, 18'd6, 1'b0);
    #2 rstn = 1'b0; i_valid = 1'b0;
    #1;
    check("mid_rst_o_valid", o_valid, 0);
    check("mid_rst_i_ready", i_ready, 1);
    check("mid_rst_o_acc", o_acc, 0);
    check("mid_rst_o_cnt", o_cnt, 0);
    check("mid_rst_o_sat", o_sat, 0);
    #1 rstn = 1'b1;
    sbq.delete();
    in_vec = 1'b0;
    repeat (5) idle();
    send(1'b0, 5'd0, 18'd7, 1'b1);
    check("post_rst_expect", sbq.size() == 1 ? sbq[0].acc : 0, 7);
    drain();

    // Random streaming with gaps and output backpressure
    rdy_mode = 2;
    gap_en   = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++)
        send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0) ? 18'd0 : 18'($urandom_range(0, 262143)), k == len - 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
